sample_frame_streamer: RTL and testbench

Reads the N-sample sliding window produced by the microphone sampling stage and delivers it, one sample per handshake, to the downstream spectrum/FFT path. Every HOP new ADC samples it snapshots the whole window into a private frame buffer, converts each 12-bit offset-binary sample to signed two's complement, and streams the frame out over a valid/ready interface with index and last markers. Frames that come due while the previous frame is still streaming are dropped and counted.

---
 rtl/audio_pkg.sv | 16 +
 rtl/frame_scheduler.sv | 44 ++++
 rtl/sample_frame_streamer.sv | 102 ++++++++++
 tb/tb_sample_frame_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample widths, signed/unsigned sample types and
// the frame streamer FSM state encoding.
package audio_pkg;

    localparam int SAMPLE_W = 12;
    localparam int MIDSCALE = 1 << (SAMPLE_W - 1);

    typedef logic        [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W-1:0] ssample_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/frame_scheduler.sv
// Decides when a frame is due: waits for the sampler window to fill,
// then fires once every HOP new samples.
module frame_scheduler
    import audio_pkg::*;
#(
    parameter int N   = 256,
    parameter int HOP = 128
) (
    input  logic clk_10MHz,
    input  logic rst_n,
    input  logic sample_strobe,
    output logic frame_due
);

    localparam int FW = $clog2(N + 1);
    localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;

    logic [FW-1:0] fill;
    logic [HW-1:0] hop;
    logic          full;
    logic          hop_wrap;

    assign full     = (fill == FW'(N));
    assign hop_wrap = full && (hop == HW'(HOP - 1));
    // The strobe that completes the window starts the first frame; after
    // that only hop wraps do.
    assign frame_due = sample_strobe && ((fill == FW'(N - 1)) || hop_wrap);

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
            hop  <= '0;
        end else if (sample_strobe) begin
            if (!full) begin
                fill <= fill + FW'(1);
            end else if (hop_wrap) begin
                hop <= '0;
            end else begin
                hop <= hop + HW'(1);
            end
        end
    end

endmodule

// File: rtl/sample_frame_streamer.sv
// Snapshots the microphone sliding window on each due frame and streams it
// out one signed sample per valid/ready handshake, counting dropped frames.
module sample_frame_streamer
    import audio_pkg::*;
#(
    parameter int N        = 256,
    parameter int HOP      = 128,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                       clk_10MHz,
    input  logic                       rst_n,
    input  logic [SAMPLE_W-1:0]        samples [0:N-1],
    input  logic                       sample_strobe,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic [$clog2(N)-1:0]       out_index,
    output logic                       out_last,
    output logic                       overrun,
    output logic [7:0]                 drop_count
);

    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

    stream_state_e       state, state_next;
    logic [IW-1:0]       idx, idx_next;
    logic                frame_due;
    logic                handshake;
    logic                frame_drop;
    logic [SAMPLE_W-1:0] frame_buf [0:N-1];

    // Offset binary to two's complement: flipping the MSB subtracts midscale.
    function automatic logic signed [SAMPLE_W-1:0] offset_to_signed(
        input logic [SAMPLE_W-1:0] s
    );
        return $signed({~s[SAMPLE_W-1], s[SAMPLE_W-2:0]});
    endfunction

    frame_scheduler #(
        .N   (N),
        .HOP (HOP)
    ) u_frame_scheduler (
        .clk_10MHz     (clk_10MHz),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .frame_due     (frame_due)
    );

    assign out_valid  = (state == STREAM);
    assign handshake  = out_valid && out_ready;
    assign frame_drop = frame_due && (state == STREAM);
    assign out_index  = idx;
    assign out_last   = out_valid && (idx == IDX_LAST);
    // Gated so the output reads zero whenever no frame is in flight.
    assign out_data   = out_valid ? offset_to_signed(frame_buf[idx]) : '0;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (state == IDLE) begin
            if (frame_due) begin
                state_next = STREAM;
                idx_next   = '0;
            end
        end else if (handshake) begin
            idx_next = idx + IW'(1);
            if (idx == IDX_LAST) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            overrun    <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (frame_drop) begin
                overrun <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Snapshot only when a frame is accepted, so the window may keep moving
    // underneath a frame that is streaming.
    always_ff @(posedge clk_10MHz) begin
        if (state == IDLE && frame_due) begin
            for (int i = 0; i < N; i++) begin
                frame_buf[i] <= samples[i];
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_streamer.sv
// Scoreboard bench for sample_frame_streamer with an 8-sample window and hop of 4.
module tb_sample_frame_streamer;

    localparam int N   = 8;
    localparam int HOP = 4;
    localparam int SW  = 12;

    logic                 clk_10MHz = 1'b0;
    logic                 rst_n;
    logic [SW-1:0]        samples [0:N-1];
    logic                 sample_strobe;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [SW-1:0] out_data;
    logic [2:0]           out_index;
    logic                 out_last;
    logic                 overrun;
    logic [7:0]           drop_count;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   sc       = 0;
    bit   accept   = 1'b1;

    always #50 clk_10MHz = ~clk_10MHz;

    sample_frame_streamer #(
        .N        (N),
        .HOP      (HOP),
        .SAMPLE_W (SW)
    ) dut (
        .clk_10MHz     (clk_10MHz),
        .rst_n         (rst_n),
        .samples       (samples),
        .sample_strobe (sample_strobe),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .overrun       (overrun),
        .drop_count    (drop_count)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_10MHz);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            sb.push_back('{idx: i, data: int'(samples[i]) - 2048});
        end
    endtask

    // Shift the window, then pulse the strobe in the following cycle.
    task automatic strobe(input logic [SW-1:0] v, output bit due);
        for (int i = 0; i < N - 1; i++) samples[i] = samples[i+1];
        samples[N-1] = v;
        tick();
        sample_strobe = 1'b1;
        sc++;
        due = (sc == N) || (sc > N && ((sc - N) % HOP) == 0);
        if (due && accept) push_frame();
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic drain(input bit bp, input int budget);
        int c;
        c = 0;
        while (sb.size() > 0 && c < budget) begin
            if (bp) begin
                out_ready = (c % 4 == 0) || (c % 4 == 3);
                for (int i = 0; i < N; i++) samples[i] = SW'($urandom_range(0, 4095));
            end
            tick();
            c++;
        end
        out_ready = 1'b1;
        check_val("drain_done", sb.size(), 0);
    endtask

    // Output monitor: pops expected beats on handshakes and checks stall hold.
    logic signed [SW-1:0] prev_data;
    logic [2:0]           prev_idx;
    bit                   prev_stall = 1'b0;

    always @(negedge clk_10MHz) begin
        exp_t e;
        if (prev_stall && out_valid) begin
            check_val("hold_data", $signed(out_data), $signed(prev_data));
            check_val("hold_index", out_index, prev_idx);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_index;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_beat", out_valid & out_ready, 0);
            end else begin
                e = sb.pop_front();
                check_val("beat_index", out_index, e.idx);
                check_val("beat_data", $signed(out_data), e.data);
                check_val("beat_last", out_last, (e.idx == N - 1) ? 1 : 0);
            end
        end
    end

    initial begin
        logic [SW-1:0] fvals [0:N-1];
        bit            due;

        fvals = '{12'd0, 12'd2048, 12'd4095, 12'd1, 12'd100, 12'd3000, 12'd2047, 12'd2049};
        rst_n         = 1'b0;
        sample_strobe = 1'b0;
        out_ready     = 1'b1;
        for (int i = 0; i < N; i++) samples[i] = '0;
        idle(3);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", $signed(out_data), 0);
        check_val("rst_index", out_index, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_drops", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // Window fill and conversion
        for (int k = 0; k < N - 1; k++) begin
            strobe(fvals[k], due);
            check_val("fill_no_valid", out_valid, 0);
            idle(1);
        end
        strobe(fvals[N-1], due);
        check_val("first_valid", out_valid, 1);
        check_val("first_index", out_index, 0);
        check_val("first_data", $signed(out_data), -2048);

        // Overlapping frame exactly HOP strobes later
        idle(1);
        for (int k = 0; k < HOP; k++) begin
            strobe(SW'($urandom_range(0, 4095)), due);
            if (k < HOP - 1) idle(1);
        end
        check_val("ovl_valid", out_valid, 1);
        check_val("ovl_index", out_index, 0);
        check_val("ovl_first", $signed(out_data), 100 - 2048);
        drain(1'b0, 20);

        // Backpressure with the window changing under the frame
        for (int k = 0; k < HOP; k++) strobe(SW'($urandom_range(0, 4095)), due);
        check_val("bp_valid", out_valid, 1);
        drain(1'b1, 64);
        check_val("no_overrun_yet", overrun, 0);

        // Overrun: consumer stalled across several hop boundaries
        out_ready = 1'b0;
        for (int k = 0; k < HOP; k++) strobe(SW'($urandom_range(0, 4095)), due);
        accept = 1'b0;
        for (int k = 0; k < 3 * HOP; k++) strobe(SW'($urandom_range(0, 4095)), due);
        check_val("ovr_flag", overrun, 1);
        check_val("ovr_drops", drop_count, 3);
        check_val("ovr_index", out_index, 0);
        check_val("ovr_valid", out_valid, 1);
        for (int k = 0; k < 256 * HOP; k++) strobe(SW'($urandom_range(0, 4095)), due);
        check_val("drop_saturate", drop_count, 255);
        check_val("sat_index", out_index, 0);
        accept = 1'b1;
        out_ready = 1'b1;
        drain(1'b0, 32);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 2 * HOP; k++) begin
            strobe(SW'($urandom_range(0, 4095)), due);
            if (due) break;
        end
        check_val("pre_rst_valid", out_valid, 1);
        idle(5);
        check_val("pre_rst_index", out_index, 5);
        #10;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_index", out_index, 0);
        check_val("arst_data", $signed(out_data), 0);
        check_val("arst_last", out_last, 0);
        check_val("arst_overrun", overrun, 0);
        check_val("arst_drops", drop_count, 0);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        sc = 0;
        tick();
        for (int k = 0; k < N - 1; k++) begin
            strobe(SW'($urandom_range(0, 4095)), due);
            check_val("refill_no_valid", out_valid, 0);
        end
        strobe(SW'($urandom_range(0, 4095)), due);
        check_val("refill_valid", out_valid, 1);
        check_val("refill_index", out_index, 0);
        drain(1'b0, 20);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
